// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that time-shares one binary-to-Gray converter among NUM_REQ requesters.
// Each grant is converted, then held on a registered valid/ready output until accepted.
module gray_conv_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned IDW     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] bin_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_gray,
  output logic [IDW-1:0]           out_id,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [7:0]               conv_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]         r_state;
  logic [IDW-1:0]     r_last_id;
  logic [WIDTH-1:0]   r_operand;
  logic [IDW-1:0]     r_id;

  logic               w_found;
  logic [IDW-1:0]     w_winner;
  logic [WIDTH-1:0]   w_win_bin;
  logic [NUM_REQ-1:0] w_gnt;

  // Two passes give round-robin order: indices above last_id first, then wrap to 0..last_id.
  always_comb begin
    w_found   = 1'b0;
    w_winner  = '0;
    w_win_bin = '0;
    w_gnt     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[k] && (IDW'(k) > r_last_id)) begin
        w_found   = 1'b1;
        w_winner  = IDW'(k);
        w_win_bin = bin_in[k*WIDTH +: WIDTH];
        w_gnt     = '0;
        w_gnt[k]  = 1'b1;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[k] && (IDW'(k) <= r_last_id)) begin
        w_found   = 1'b1;
        w_winner  = IDW'(k);
        w_win_bin = bin_in[k*WIDTH +: WIDTH];
        w_gnt     = '0;
        w_gnt[k]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_id  <= IDW'(NUM_REQ - 1);
      r_operand  <= '0;
      r_id       <= '0;
      gnt        <= '0;
      out_valid  <= 1'b0;
      out_gray   <= '0;
      out_id     <= '0;
      conv_count <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_operand <= w_win_bin;
            r_id      <= w_winner;
            r_last_id <= w_winner;
            gnt       <= w_gnt;
            r_state   <= S_CONV;
          end
        end
        S_CONV: begin
          gnt       <= '0;
          out_gray  <= r_operand ^ (r_operand >> 1);
          out_id    <= r_id;
          out_valid <= 1'b1;
          r_state   <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            conv_count <= conv_count + 8'd1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed-vector bench for gray_conv_arbiter: reset, single request, round-robin,
// backpressure, conversion sweep, asynchronous reset and conv_count wrap.
module tb_gray_conv_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] bin_in;
  logic [3:0]  gnt;
  logic        out_valid;
  logic [3:0]  out_gray;
  logic [2:0]  out_id;
  logic        out_ready;
  logic        busy;
  logic [7:0]  conv_count;

  int n_vec;
  int n_bad;

  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_conv_arbiter #(
    .NUM_REQ(4),
    .WIDTH  (4),
    .IDW    (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bin_in    (bin_in),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_gray  (out_gray),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy),
    .conv_count(conv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    bin_in = '0;
    out_ready = 1'b0;
    tick();
    n_vec++;
    if ({gnt, out_valid, out_gray, out_id, busy, conv_count} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got gnt=%b v=%b g=%h id=%0d busy=%b cnt=%0d want all 0",
               gnt, out_valid, out_gray, out_id, busy, conv_count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bin_in = 16'h000B;
    req = 4'b0001;
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_gnt: got gnt=%b busy=%b want gnt=0001 busy=1", gnt, busy);
    end
    req = 4'b0000;
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || out_valid !== 1'b1 || out_gray !== 4'b1110 || out_id !== 3'd0) begin
      n_bad++;
      $display("FAIL single_result: got gnt=%b v=%b g=%b id=%0d want 0000 1 1110 0",
               gnt, out_valid, out_gray, out_id);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || conv_count !== 8'd1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_accept: got v=%b cnt=%0d busy=%b want 0 1 0",
               out_valid, conv_count, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    // Fresh reset so the order starts at requester 0.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bin_in = 16'h3210;
    req = 4'b1111;
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      exp_g = 4'b0001 << (j % 4);
      tick();
      n_vec++;
      if (gnt !== exp_g) begin
        n_bad++;
        $display("FAIL rr_gnt[%0d]: got %b want %b", j, gnt, exp_g);
      end
      tick();
      n_vec++;
      if (gnt !== 4'b0000 || out_valid !== 1'b1 || out_id !== 3'(j % 4)
          || out_gray !== gray_tab[j % 4]) begin
        n_bad++;
        $display("FAIL rr_result[%0d]: got gnt=%b v=%b id=%0d g=%h want 0000 1 %0d %h",
                 j, gnt, out_valid, out_id, out_gray, j % 4, gray_tab[j % 4]);
      end
      tick();
    end
    req = 4'b0000;
    n_vec++;
    if (conv_count !== 8'd6 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rr_count: got cnt=%0d busy=%b want 6 0", conv_count, busy);
    end
  endtask

  task automatic test_backpressure();
    bin_in = 16'h0700;
    req = 4'b0100;
    out_ready = 1'b0;
    tick();
    n_vec++;
    if (gnt !== 4'b0100) begin
      n_bad++;
      $display("FAIL bp_gnt: got %b want 0100", gnt);
    end
    req = 4'b0000;
    tick();
    // Requester 0 asks while the result is stalled; it must wait for IDLE.
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_gray !== 4'b0100 || out_id !== 3'd2 || gnt !== 4'b0000
          || conv_count !== 8'd6) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got v=%b g=%b id=%0d gnt=%b cnt=%0d want 1 0100 2 0000 6",
                 i, out_valid, out_gray, out_id, gnt, conv_count);
      end
      tick();
    end
    n_vec++;
    if (out_valid !== 1'b1 || conv_count !== 8'd6) begin
      n_bad++;
      $display("FAIL bp_still_held: got v=%b cnt=%0d want 1 6", out_valid, conv_count);
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || conv_count !== 8'd7 || gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_accept: got v=%b cnt=%0d gnt=%b busy=%b want 0 7 0000 0",
               out_valid, conv_count, gnt, busy);
    end
    tick();
    n_vec++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL bp_pending_gnt: got %b want 0001", gnt);
    end
    req = 4'b0000;
    tick();
    tick();
    n_vec++;
    if (conv_count !== 8'd8) begin
      n_bad++;
      $display("FAIL bp_pending_count: got %0d want 8", conv_count);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] prev;
    prev = 4'h0;
    out_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      bin_in = {8'h00, 4'(b), 4'h0};
      req = 4'b0010;
      tick();
      n_vec++;
      if (gnt !== 4'b0010) begin
        n_bad++;
        $display("FAIL sweep_gnt[%0d]: got %b want 0010", b, gnt);
      end
      req = 4'b0000;
      bin_in = 16'hFFFF;
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_gray !== gray_tab[b] || out_id !== 3'd1) begin
        n_bad++;
        $display("FAIL sweep_gray[%0d]: got v=%b g=%b id=%0d want 1 %b 1",
                 b, out_valid, out_gray, out_id, gray_tab[b]);
      end
      if (b > 0) begin
        n_vec++;
        if ($countones(out_gray ^ prev) != 1) begin
          n_bad++;
          $display("FAIL sweep_onebit[%0d]: got %b after %b want one-bit change",
                   b, out_gray, prev);
        end
      end
      prev = out_gray;
      tick();
    end
    n_vec++;
    if (conv_count !== 8'd24) begin
      n_bad++;
      $display("FAIL sweep_count: got %0d want 24", conv_count);
    end
  endtask

  task automatic test_async_reset();
    bin_in = 16'h800A;
    req = 4'b0001;
    out_ready = 1'b0;
    tick();
    req = 4'b0000;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_pre: got v=%b busy=%b want 1 1", out_valid, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0 || conv_count !== 8'd0
        || out_gray !== 4'h0 || out_id !== 3'd0) begin
      n_bad++;
      $display("FAIL areset_async: got v=%b gnt=%b busy=%b cnt=%0d g=%h id=%0d want all 0",
               out_valid, gnt, busy, conv_count, out_gray, out_id);
    end
    #1;
    rst = 1'b0;
    req = 4'b1000;
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (gnt !== 4'b1000 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL areset_first_gnt: got gnt=%b v=%b want 1000 0", gnt, out_valid);
    end
    req = 4'b0000;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_id !== 3'd3 || out_gray !== 4'b1100) begin
      n_bad++;
      $display("FAIL areset_result: got v=%b id=%0d g=%b want 1 3 1100",
               out_valid, out_id, out_gray);
    end
    tick();
    n_vec++;
    if (conv_count !== 8'd1) begin
      n_bad++;
      $display("FAIL areset_count: got %0d want 1", conv_count);
    end
  endtask

  task automatic test_wrap();
    bin_in = 16'h0005;
    req = 4'b0001;
    out_ready = 1'b1;
    for (int i = 0; i < 254; i++) begin
      tick();
      tick();
      tick();
    end
    n_vec++;
    if (conv_count !== 8'd255) begin
      n_bad++;
      $display("FAIL wrap_255: got %0d want 255", conv_count);
    end
    tick();
    tick();
    tick();
    req = 4'b0000;
    n_vec++;
    if (conv_count !== 8'd0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_0: got cnt=%0d v=%b want 0 0", conv_count, out_valid);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_sweep();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Round-robin arbiter and sequencer that shares one binary-to-Gray conversion datapath (G[W-1] = B[W-1], G[i] = B[i+1] ^ B[i]) among NUM_REQ requesters. Each request is granted, converted and presented on a registered output with a valid/ready handshake. The block sits between requester ports and a single downstream Gray-code consumer and holds each result until that consumer accepts it.

## Interface
- NUM_REQ, 4: number of requesters; legal values 2..8.
- WIDTH, 4: bits per binary operand and Gray result.
- IDW, 3: width of the requester ID field; at least ceil(log2(NUM_REQ)).

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- req  in  NUM_REQ  per-requester request; held high until the matching gnt bit is seen.
- bin_in  in  NUM_REQ*WIDTH  flat operand bus; requester k occupies bits [k*WIDTH +: WIDTH].
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse; the operand was captured on the edge that raised it.
- out_valid  out  1  result valid.
- out_gray  out  WIDTH  Gray-coded result.
- out_id  out  IDW  index of the requester that owns out_gray.
- out_ready  in  1  downstream accept.
- busy  out  1  high whenever state is not IDLE.
- conv_count  out  8  number of accepted results; wraps 255 -> 0.

## Operation
- States:
  - IDLE: waiting for a request.
  - CONV: applying the conversion to the latched operand.
  - HOLD: presenting the result until it is accepted.
- IDLE, req == 0: remain in IDLE.
- IDLE, req != 0, at the edge:
  - Pick the winner: the first set req bit searching upward from (last_id+1) mod NUM_REQ.
  - Latch bin_in[winner] into the operand register and winner into the ID register.
  - Set gnt[winner]=1 and last_id=winner; go to CONV.
- CONV, at the edge:
  - gnt <= 0.
  - out_gray <= operand ^ (operand >> 1), zero-filled logical shift, WIDTH bits, no carry.
  - out_id <= latched ID; out_valid <= 1; go to HOLD.
- HOLD, out_ready == 0: out_valid, out_gray and out_id stay constant.
- HOLD, out_ready == 1, at the edge:
  - out_valid <= 0; conv_count <= conv_count+1 (mod 256).
  - Go to IDLE. No arbitration on the same edge.
- req, bin_in and out_ready are ignored in states where they are not listed above.
- A requester that keeps req high after its gnt is treated as a new request and is considered at the next IDLE.
- Requests that are high during CONV or HOLD are neither lost nor latched early; they are evaluated when the block returns to IDLE.
- Out-of-range requester indices (above NUM_REQ-1) are never granted.

## Timing
- Reset value of every output and of internal state:
  - req-facing and result outputs: gnt=0, out_valid=0, out_gray=0, out_id=0, busy=0, conv_count=0.
  - Internal: state=IDLE, last_id=NUM_REQ-1, so requester 0 wins first.
- Reset asserted in any state forces these values immediately, without waiting for clk. Any in-flight operand or result is discarded and never presented.
- Latency:
  - Edge E0 samples req in IDLE; gnt is high during cycle E0..E1.
  - out_valid rises at E1.
  - With out_ready held high, the result is accepted at E2 and the next grant can occur at E3.
  - Minimum spacing between grants is 3 cycles.
- out_valid falls only on an accepting edge or on reset.
- busy = (state != IDLE) is combinational from the state register and is high during the gnt cycle.
- conv_count increments exactly once per accepted result.

## Test plan
- Single request:
  - Stimulus: after reset, req=4'b0001 with bin_in[3:0]=4'b1011.
  - Response: gnt=4'b0001 for one cycle; next cycle out_valid=1, out_gray=4'b1110, out_id=0; with out_ready=1, conv_count=1 and busy=0 one cycle later.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held, out_ready=1.
  - Response: grant order 0,1,2,3,0,1, each spaced 3 cycles; out_id follows the same order.
- Backpressure:
  - Stimulus: requester 2 with bin 4'b0111, out_ready=0 for 5 cycles, then 1.
  - Response: out_valid=1 and out_gray=4'b0100, out_id=2 stable for all 5 cycles; exactly one acceptance; conv_count +1; no new gnt until IDLE.
- Conversion sweep:
  - Stimulus: requester 1 drives bin 0..15 in sequence.
  - Response: every out_gray equals bin ^ (bin>>1), including 4'b1000->4'b1100 and 4'b1111->4'b1000; consecutive results differ in exactly one bit.
- Asynchronous reset mid-operation:
  - Stimulus: assert rst between edges while in HOLD with out_valid=1.
  - Response: out_valid, gnt, busy and conv_count go to 0 before the next edge; after release with req=4'b1000, the first grant is to requester 3.
- conv_count wrap:
  - Stimulus: 256 accepted results.
  - Response: conv_count reads 255, then 0 on the 256th acceptance.
